// File: rtl/prod_seq_acc.sv
// Four-product sequence accumulator with a 2-entry result FIFO, drop accounting and restart detection.
// Optional product checker is enabled by defining PROD_SEQ_CHECK_EN.
module prod_seq_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_grant,
    input  logic [10:0] in_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [12:0] out_sum,
    output logic [7:0]  out_d,
    output logic        seq_err,
    output logic        ovf,
    output logic [7:0]  drop_cnt,
    output logic        chk_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]  state_reg;
    logic [1:0]  idx_reg;
    logic [12:0] acc_reg;
    logic [10:0] first_reg;
    logic        seq_err_reg;
    logic        ovf_reg;
    logic [7:0]  drop_cnt_reg;

    logic [20:0] mem_reg [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;

    logic [12:0] sum_next;
    logic        restart;
    logic        push;
    logic        pop;
    logic        full;
    logic        push_ok;

    assign sum_next = acc_reg + {2'b00, in_data};
    assign restart  = (state_reg == ACC) && in_grant;
    assign push     = (state_reg == ACC) && !in_grant && (idx_reg == 2'd3);
    assign pop      = out_valid && out_ready;
    assign full     = (count_reg == 2'd2);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= 2'd0;
            acc_reg     <= 13'd0;
            first_reg   <= 11'd0;
            seq_err_reg <= 1'b0;
        end else begin
            seq_err_reg <= restart;
            if (in_grant) begin
                state_reg <= ACC;
                idx_reg   <= 2'd1;
                acc_reg   <= {2'b00, in_data};
                first_reg <= in_data;
            end else if (state_reg == ACC) begin
                acc_reg <= sum_next;
                if (idx_reg == 2'd3) begin
                    state_reg <= IDLE;
                    idx_reg   <= 2'd0;
                end else begin
                    idx_reg <= idx_reg + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= 21'd0;
            end
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            ovf_reg <= push && !push_ok;
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= {sum_next, first_reg[7:0]};
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop};
            if (push && !push_ok && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign out_valid = (count_reg != 2'd0);
    assign out_sum   = mem_reg[rd_ptr_reg][20:8];
    assign out_d     = mem_reg[rd_ptr_reg][7:0];
    assign seq_err   = seq_err_reg;
    assign ovf       = ovf_reg;
    assign drop_cnt  = drop_cnt_reg;

`ifdef PROD_SEQ_CHECK_EN
    logic [13:0] expect_prod;
    logic        mismatch;
    logic        chk_err_reg;

    always_comb begin
        expect_prod = {3'b000, first_reg} * 14'd8;
        case (idx_reg)
            2'd1:    expect_prod = {3'b000, first_reg} * 14'd3;
            2'd2:    expect_prod = {3'b000, first_reg} * 14'd7;
            default: expect_prod = {3'b000, first_reg} * 14'd8;
        endcase
    end

    assign mismatch = (state_reg == ACC) && !in_grant && ({3'b000, in_data} != expect_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_reg <= 1'b0;
        end else begin
            chk_err_reg <= mismatch;
        end
    end

    assign chk_err = chk_err_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule
